board_ctrl: RTL

//  Tic-tac-toe game sequencer for the 3x3 board. Takes the square under the mouse

---
 rtl/board_ctrl_if.sv | 24 ++
 rtl/board_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl_if.sv
// Cursor/click inputs and game-state outputs exchanged between the mouse decoder,
// the tic-tac-toe sequencer and the VGA draw pipeline.
interface board_ctrl_if;
  logic       start_en;
  logic [3:0] hover_sq;
  logic       click;
  logic [8:0] square_en;
  logic [8:0] x_mask;
  logic [8:0] o_mask;
  logic       turn;
  logic       game_over;
  logic [1:0] winner;
  logic [7:0] win_line;

  modport master (
    output start_en, hover_sq, click,
    input  square_en, x_mask, o_mask, turn, game_over, winner, win_line
  );

  modport slave (
    input  start_en, hover_sq, click,
    output square_en, x_mask, o_mask, turn, game_over, winner, win_line
  );
endinterface

// File: rtl/board_ctrl.sv
// Tic-tac-toe sequencer: tracks X/O occupancy and turn, scans the eight lines after
// each move, and drives the per-square highlight enables (hover or blinking win line).
module board_ctrl #(
  parameter bit FIRST_PLAYER = 1'b0,
  parameter int BLINK_DIV    = 24
) (
  input  logic         pclk,
  input  logic         rst,
  board_ctrl_if.slave  bus
);

  localparam int BW = BLINK_DIV + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK,
    S_OVER,
    S_CLEAR
  } state_t;

  state_t         state;
  logic [8:0]     x_mask;
  logic [8:0]     o_mask;
  logic [8:0]     square_en;
  logic           turn;
  logic           game_over;
  logic [1:0]     winner;
  logic [7:0]     win_line;
  logic [2:0]     line_idx;
  logic           win_flag;
  logic [2:0]     win_idx;
  logic [BW-1:0]  blink;

  logic           hover_ok;
  logic [8:0]     hover_oh;
  logic           sq_free;
  logic [8:0]     mover_mask;
  logic [8:0]     cur_line;
  logic           line_hit;
  logic           win_final;
  logic [2:0]     line_final;
  logic           board_full;
  logic [BW-1:0]  blink_nx;

  // Squares of each line, bit k-1 = square K.
  function automatic logic [8:0] line_mask(input logic [2:0] idx);
    logic [8:0] m;
    case (idx)
      3'd0:    m = 9'h007;
      3'd1:    m = 9'h038;
      3'd2:    m = 9'h1C0;
      3'd3:    m = 9'h049;
      3'd4:    m = 9'h092;
      3'd5:    m = 9'h124;
      3'd6:    m = 9'h111;
      default: m = 9'h054;
    endcase
    return m;
  endfunction

  always_comb begin
    hover_ok   = (bus.hover_sq >= 4'd1) && (bus.hover_sq <= 4'd9);
    hover_oh   = hover_ok ? (9'd1 << (bus.hover_sq - 4'd1)) : 9'd0;
    sq_free    = hover_ok && (((x_mask | o_mask) & hover_oh) == 9'd0);
    mover_mask = turn ? o_mask : x_mask;
    cur_line   = line_mask(line_idx);
    line_hit   = (mover_mask & cur_line) == cur_line;
    // A hit on the current line outranks any earlier (lower-index) hit.
    win_final  = win_flag | line_hit;
    line_final = line_hit ? line_idx : win_idx;
    board_full = (x_mask | o_mask) == 9'h1FF;
    blink_nx   = blink + 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state     <= S_IDLE;
      x_mask    <= '0;
      o_mask    <= '0;
      square_en <= '0;
      turn      <= FIRST_PLAYER;
      game_over <= 1'b0;
      winner    <= 2'b00;
      win_line  <= '0;
      line_idx  <= '0;
      win_flag  <= 1'b0;
      win_idx   <= '0;
      blink     <= '0;
    end else if (!bus.start_en) begin
      // Leaving the game screen abandons the game; turn is left as it was.
      state     <= S_IDLE;
      x_mask    <= '0;
      o_mask    <= '0;
      square_en <= '0;
      game_over <= 1'b0;
      winner    <= 2'b00;
      win_line  <= '0;
      line_idx  <= '0;
      win_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_PLAY;
          x_mask    <= '0;
          o_mask    <= '0;
          square_en <= '0;
          turn      <= FIRST_PLAYER;
        end

        S_PLAY: begin
          if (bus.click && sq_free) begin
            if (turn) o_mask <= o_mask | hover_oh;
            else      x_mask <= x_mask | hover_oh;
            state     <= S_CHECK;
            line_idx  <= '0;
            win_flag  <= 1'b0;
            win_idx   <= '0;
            square_en <= '0;
          end else begin
            square_en <= sq_free ? hover_oh : 9'd0;
          end
        end

        S_CHECK: begin
          square_en <= '0;
          line_idx  <= line_idx + 3'd1;
          win_flag  <= win_final;
          win_idx   <= line_final;
          if (line_idx == 3'd7) begin
            if (win_final) begin
              state     <= S_OVER;
              game_over <= 1'b1;
              winner    <= turn ? 2'b10 : 2'b01;
              win_line  <= 8'd1 << line_final;
              blink     <= '0;
              square_en <= line_mask(line_final);
            end else if (board_full) begin
              state     <= S_OVER;
              game_over <= 1'b1;
              winner    <= 2'b11;
              win_line  <= '0;
              blink     <= '0;
            end else begin
              turn  <= ~turn;
              state <= S_PLAY;
            end
          end
        end

        S_OVER: begin
          if (bus.click) begin
            state     <= S_CLEAR;
            x_mask    <= '0;
            o_mask    <= '0;
            square_en <= '0;
            game_over <= 1'b0;
            winner    <= 2'b00;
            win_line  <= '0;
            turn      <= FIRST_PLAYER;
          end else begin
            // Counter phase low = lit, so the line shows immediately on entry.
            blink     <= blink_nx;
            square_en <= win_flag ? (line_mask(win_idx) & {9{~blink_nx[BW-1]}}) : 9'd0;
          end
        end

        S_CLEAR: begin
          state     <= S_PLAY;
          x_mask    <= '0;
          o_mask    <= '0;
          square_en <= '0;
          winner    <= 2'b00;
          win_line  <= '0;
          turn      <= FIRST_PLAYER;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.square_en = square_en;
  assign bus.x_mask    = x_mask;
  assign bus.o_mask    = o_mask;
  assign bus.turn      = turn;
  assign bus.game_over = game_over;
  assign bus.winner    = winner;
  assign bus.win_line  = win_line;

endmodule
